// File: rtl/led_breather.sv
// Breathing PWM on LED4 plus a one-hot chaser on LED3..LED0, all from one clock.
// Latency: LEDs are registered, one cycle after the state they show; no input-to-output path.
module led_breather #(
  parameter int PRESCALE_W = 14,
  parameter int PWM_W      = 8,
  parameter int CHASE_DIV  = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic LED4,
  output logic LED3,
  output logic LED2,
  output logic LED1,
  output logic LED0
);

  localparam logic [PWM_W-1:0]  MAX       = '1;
  localparam int                STEP_W    = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CHASE_DIV - 1);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [PRESCALE_W-1:0] presc;
  logic [PWM_W-1:0]      pwm_cnt;
  logic [PWM_W-1:0]      duty;
  dir_t                  dir;
  logic [STEP_W-1:0]     step;
  logic [3:0]            pos;
  logic                  tick;

  assign tick = EN && (presc == '1);

  // Both free-running counters wrap naturally at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (EN) begin
      presc   <= presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Ramp FSM: endpoints turn around immediately so neither is held for two ticks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dir  <= UP;
      duty <= '0;
    end else if (tick) begin
      case (dir)
        UP: begin
          if (duty == MAX) begin
            dir  <= DOWN;
            duty <= MAX - 1'b1;
          end else begin
            duty <= duty + 1'b1;
          end
        end
        DOWN: begin
          if (duty == '0) begin
            dir  <= UP;
            duty <= PWM_W'(1);
          end else begin
            duty <= duty - 1'b1;
          end
        end
        default: begin
          dir  <= UP;
          duty <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      step <= '0;
      pos  <= 4'b0001;
    end else if (tick) begin
      if (step == STEP_LAST) begin
        step <= '0;
        pos  <= {pos[2:0], pos[3]};
      end else begin
        step <= step + 1'b1;
      end
    end
  end

  // Outputs show the pre-update state; EN low blanks them on the next edge.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      LED4 <= 1'b0;
      LED3 <= 1'b0;
      LED2 <= 1'b0;
      LED1 <= 1'b0;
      LED0 <= 1'b0;
    end else begin
      LED4 <= (pwm_cnt < duty);
      LED3 <= pos[3];
      LED2 <= pos[2];
      LED1 <= pos[1];
      LED0 <= pos[0];
    end
  end

  a_pos_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot(pos));
  a_step_range: assert property (@(posedge CLK) disable iff (RST) step <= STEP_LAST);

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench: stimulus pushes expected LED vectors from an arithmetic model; a monitor pops and compares.
module tb_led_breather;

  localparam int PW   = 2;
  localparam int WW   = 3;
  localparam int CDIV = 2;
  localparam int MAXV = (1 << WW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic led4, led3, led2, led1, led0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [4:0] exp_q[$];

  // Model state: enabled cycles since reset and ramp ticks since reset.
  int n_en  = 0;
  int ticks = 0;

  led_breather #(.PRESCALE_W(PW), .PWM_W(WW), .CHASE_DIV(CDIV)) dut (
    .CLK (clk),
    .RST (rst),
    .EN  (en),
    .LED4(led4),
    .LED3(led3),
    .LED2(led2),
    .LED1(led1),
    .LED0(led0)
  );

  always #5 clk = ~clk;

  // Triangle wave over 2*MAX ticks.
  function automatic int duty_of(input int t);
    int p;
    p = t % (2 * MAXV);
    return (p <= MAXV) ? p : (2 * MAXV - p);
  endfunction

  function automatic logic [3:0] pos_of(input int t);
    logic [3:0] one;
    one = 4'b0001;
    return one << ((t / CDIV) % 4);
  endfunction

  task automatic drive(input logic r, input logic e);
    logic [4:0] exp_v;
    rst = r;
    en  = e;
    if (r) begin
      exp_v = 5'b0;
      n_en  = 0;
      ticks = 0;
    end else if (!e) begin
      exp_v = 5'b0;
    end else begin
      exp_v[4]   = ((n_en % (1 << WW)) < duty_of(ticks));
      exp_v[3:0] = pos_of(ticks);
      if ((n_en % (1 << PW)) == (1 << PW) - 1) ticks++;
      n_en++;
    end
    exp_q.push_back(exp_v);
    @(negedge clk);
  endtask

  task automatic run(input logic r, input logic e, input int count);
    for (int i = 0; i < count; i++) drive(r, e);
  endtask

  initial begin : monitor
    logic [4:0] got;
    logic [4:0] want;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {led4, led3, led2, led1, led0};
        checks++;
        if (got !== want) begin
          fails++;
          $display("FAIL leds cycle %0d: got %b expected %b", cyc, got, want);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    // Reset with EN high, then ramp to duty=4/pos=0100 and gate EN.
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 16);
    run(1'b0, 1'b0, 20);
    // Resume to 23 ticks total: duty=5 falling, pos=1000, then reset mid-op.
    run(1'b0, 1'b1, 76);
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 64);
    // Reset has priority over a low enable.
    run(1'b1, 1'b0, 2);
    run(1'b0, 1'b1, 120);
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 150) == 0, ($urandom % 6) != 0);
    end
    run(1'b0, 1'b1, 8);
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
Drives the five board LEDs (LED4..LED0) from the 12 MHz CLK. LED4 "breathes": a PWM output whose duty ramps up then down. LED3..LED0 run a one-hot chaser. It replaces the free-running counter stage as the producer of LED outputs, sitting directly between CLK and the top-level LED pins.

Parameters:
PRESCALE_W, 14, prescaler width; one ramp tick every 2^PRESCALE_W enabled cycles (~1.37 ms at 12 MHz)
PWM_W, 8, PWM counter and duty width; MAX = 2^PWM_W-1
CHASE_DIV, 64, ramp ticks per chaser step; legal range 1..2^16

Ports:
CLK   in   1  system clock, 12 MHz
RST   in   1  synchronous reset, active-high
EN    in   1  run enable; low freezes all state and blanks the LEDs
LED4  out  1  breathing PWM output
LED3  out  1  chaser bit 3
LED2  out  1  chaser bit 2
LED1  out  1  chaser bit 1
LED0  out  1  chaser bit 0

Behaviour:
- Single clock domain. All state updates on posedge CLK. RST is sampled synchronously, is active-high, and has priority over EN.
- Reset values: presc=0, pwm_cnt=0, duty=0, dir=UP, step=0, pos=4'b0001. LED4..LED0 all 0.
- All LED outputs are registered. No combinational path from any input to any output.
- Prescaler: when EN=1, presc increments each cycle and wraps at all-ones. Internal strobe tick = EN && (presc == all-ones), so the first tick comes on the 2^PRESCALE_W-th enabled cycle after reset.
- PWM: when EN=1, pwm_cnt increments each cycle and wraps at MAX. LED4 is registered from (pwm_cnt < duty), giving 1-cycle latency.
  - duty=0: LED4 is always 0.
  - duty=MAX: LED4 is high for MAX of every 2^PWM_W cycles.
- Ramp FSM, states UP and DOWN; updates only on tick.
  - UP: if duty==MAX, go to DOWN and set duty=MAX-1; otherwise duty+1.
  - DOWN: if duty==0, go to UP and set duty=1; otherwise duty-1.
  - Full breath period is 2*MAX ticks. duty never leaves 0..MAX. Neither endpoint value is held for two consecutive ticks.
- Chaser: on tick, step increments. When step==CHASE_DIV-1 on a tick, step returns to 0 and pos rotates left (0001->0010->0100->1000->0001).
  - {LED3,LED2,LED1,LED0} is registered from pos when EN=1.
  - pos is always exactly one-hot.
- EN=0: presc, pwm_cnt, duty, dir, step and pos all hold. LED4..LED0 register 0 on the next edge.
  - When EN returns to 1, counting resumes from the held values.
  - LEDs show the held pos, and PWM output reappears on the next edge.
- RST mid-operation: all state returns to reset values on that edge, regardless of dir or duty.
- Tick coinciding with a chaser wrap and a ramp turnaround in the same cycle: all three updates apply on that edge independently.

Test Plan:
All scenarios use PRESCALE_W=2, PWM_W=3 (MAX=7), CHASE_DIV=2, so one tick every 4 cycles.

1. Reset: RST=1 for 3 cycles with EN=1 -> LED4..LED0=0 throughout. At the 1st posedge after RST falls, {LED3..LED0}=0001 and LED4=0.
2. Ramp up: EN=1 for 28 cycles (7 ticks) -> duty=7, dir=UP. Over the next 8 cycles LED4 is high exactly 7 cycles (duty 8th tick not yet applied).
3. Turnaround: continue to tick 8 -> duty=6, dir=DOWN. At tick 14, duty=0 and LED4 is 0 for a full 8-cycle window. At tick 15, duty=1 and dir=UP.
4. Chaser: from reset, pos rotates every 8 cycles: 0001, 0010, 0100, 1000. After 32 enabled cycles it is back to 0001; exactly one LED of LED3..LED0 is high in every enabled cycle.
5. Enable gating: at duty=4, pos=0100, drop EN for 20 cycles -> LED4..LED0=0 from the next edge. Raise EN -> LEDs show 0100, and duty is still 4 at resumption.
6. Reset mid-op: at duty=5, dir=DOWN, pos=1000, pulse RST 1 cycle -> next edge has duty=0, dir=UP, pos=0001, LED4..LED0=0. The first tick comes 4 enabled cycles after release and sets duty=1.
